// File: rtl/maria_bus_arbiter.sv
// Address-bus arbiter between the 6502 and Maria DMA: halts the CPU on a phase-2 fall,
// grants the bus after a turnaround gap, bounds burst length and enforces CPU fairness.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | CPU owns the bus; cpu_ok re-armed by a CPU phase-2 fall
// HALT_WAIT | halt_b low, waiting for a CPU-cycle boundary (phase-2 fall)
// SETTLE    | CPU halted, bus turnaround for SETTLE_CYC cycles
// DMA       | DMA owns and drives the address bus
// RELEASE   | one-cycle handback; CPU gets at least one cycle before next burst
module maria_bus_arbiter #(
  parameter int SETTLE_CYC  = 2,
  parameter int MAX_DMA_CYC = 452,
  parameter int CNT_W       = 10
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             pclk_2,
  input  logic             dma_req,
  input  logic             dma_done,
  input  logic [15:0]      dma_ab,
  output logic             halt_b,
  output logic             dma_grant,
  output logic             drive_AB,
  output logic [15:0]      AB_out,
  output logic             dma_kill,
  output logic [CNT_W-1:0] dma_cycles
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_SETTLE    = 3'd2,
    S_DMA       = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DMA_LAST    = CNT_W'(MAX_DMA_CYC - 1);
  localparam logic [CNT_W-1:0] DMA_MAX     = CNT_W'(MAX_DMA_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dma_cycles_q, dma_cycles_d;
  logic             pclk_2_q;
  logic             cpu_ok_q, cpu_ok_d;
  logic             kill_q, kill_d;
  logic             cpu_fall;

  assign cpu_fall = pclk_2_q & ~pclk_2;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dma_cycles_q <= '0;
      pclk_2_q     <= 1'b0;
      cpu_ok_q     <= 1'b1;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dma_cycles_q <= dma_cycles_d;
      pclk_2_q     <= pclk_2;
      cpu_ok_q     <= cpu_ok_d;
      kill_q       <= kill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dma_cycles_d = dma_cycles_q;
    cpu_ok_d     = cpu_ok_q;
    kill_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cpu_fall) cpu_ok_d = 1'b1;
        if (dma_req && cpu_ok_q) state_d = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        // an abort takes priority over a coincident CPU boundary
        if (!dma_req) begin
          state_d = S_IDLE;
        end else if (cpu_fall) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DMA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DMA: begin
        if (dma_done) begin
          state_d      = S_RELEASE;
          dma_cycles_d = cnt_q + CNT_ONE;
          cnt_d        = '0;
        end else if (cnt_q == DMA_LAST) begin
          state_d      = S_RELEASE;
          dma_cycles_d = DMA_MAX;
          kill_d       = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        cpu_ok_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs decoded from registered state only; AB_out is the lone combinational path
  assign halt_b     = ~((state_q == S_HALT_WAIT) || (state_q == S_SETTLE) || (state_q == S_DMA));
  assign dma_grant  = (state_q == S_DMA);
  assign drive_AB   = (state_q == S_DMA);
  assign AB_out     = (state_q == S_DMA) ? dma_ab : 16'h0000;
  assign dma_kill   = kill_q;
  assign dma_cycles = dma_cycles_q;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Directed bench for maria_bus_arbiter: grant latency, done/kill release, fairness,
// abort, and reset mid-burst, with hand-computed expectations.
module tb_maria_bus_arbiter;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        pclk_2;
  logic        dma_req;
  logic        dma_done;
  logic [15:0] dma_ab;
  logic        halt_b;
  logic        dma_grant;
  logic        drive_AB;
  logic [15:0] AB_out;
  logic        dma_kill;
  logic [9:0]  dma_cycles;

  int vec_cnt = 0;
  int err_cnt = 0;

  maria_bus_arbiter #(.SETTLE_CYC(2), .MAX_DMA_CYC(452), .CNT_W(10)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .pclk_2    (pclk_2),
    .dma_req   (dma_req),
    .dma_done  (dma_done),
    .dma_ab    (dma_ab),
    .halt_b    (halt_b),
    .dma_grant (dma_grant),
    .drive_AB  (drive_AB),
    .AB_out    (AB_out),
    .dma_kill  (dma_kill),
    .dma_cycles(dma_cycles)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {halt_b, dma_grant, drive_AB, dma_kill, AB_out}
  function automatic logic [19:0] outs();
    return {halt_b, dma_grant, drive_AB, dma_kill, AB_out};
  endfunction

  initial begin
    logic bad;
    reset = 1'b1; pclk_2 = 1'b0; dma_req = 1'b0; dma_done = 1'b0; dma_ab = 16'h0000;
    repeat (3) tick();
    chk("reset_outs", outs(), {4'b1000, 16'h0000});
    chk("reset_cycles", dma_cycles, 0);
    reset = 1'b0;

    // idle with phase-2 toggling
    for (int i = 0; i < 16; i++) begin
      pclk_2 = ((i / 4) % 2) == 1;
      tick();
      chk("idle_outs", outs(), {4'b1000, 16'h0000});
    end

    // request, halt, fall three cycles later, settle, grant
    pclk_2 = 1'b1; dma_ab = 16'hF123; dma_req = 1'b1;
    tick();
    chk("hw_halt", halt_b, 0);
    chk("hw_grant", dma_grant, 0);
    tick(); tick();
    pclk_2 = 1'b0;
    tick();
    chk("settle0_outs", outs(), {4'b0000, 16'h0000});
    tick();
    chk("settle1_grant", dma_grant, 0);
    tick();
    chk("dma_outs", outs(), {4'b0110, 16'hF123});
    dma_ab = 16'h1234;
    #1;
    chk("ab_track", AB_out, 16'h1234);
    dma_ab = 16'hF123;

    // done in DMA cycle 10
    repeat (9) tick();
    chk("dma10_grant", dma_grant, 1);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("rel_outs", outs(), {4'b1000, 16'h0000});
    chk("rel_cycles", dma_cycles, 10);

    // fairness: request held, no re-halt until a fall is seen in IDLE
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("fair_wait", halt_b, 1);
      tick();
    end
    pclk_2 = 1'b1;
    tick();
    chk("fair_rise", halt_b, 1);
    pclk_2 = 1'b0;
    tick();
    chk("fair_fall", halt_b, 1);
    tick();
    chk("fair_rehalt", halt_b, 0);

    // abort in HALT_WAIT
    dma_req = 1'b0;
    tick();
    chk("abort_halt", halt_b, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_idle", outs(), {4'b1000, 16'h0000});
    end
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("done_idle_cycles", dma_cycles, 10);
    chk("done_idle_outs", outs(), {4'b1000, 16'h0000});

    // done coincident with the limit: done wins
    pclk_2 = 1'b1; dma_req = 1'b1;
    tick();
    pclk_2 = 1'b0;
    tick();
    tick(); tick();
    chk("dl_grant", dma_grant, 1);
    repeat (451) tick();
    chk("dl_c452_grant", dma_grant, 1);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("dl_kill", dma_kill, 0);
    chk("dl_cycles", dma_cycles, 452);
    chk("dl_grant_off", dma_grant, 0);
    tick();
    chk("dl_kill_late", dma_kill, 0);

    // reset during DMA cycle 5
    pclk_2 = 1'b1;
    tick();
    pclk_2 = 1'b0;
    tick();
    tick();
    chk("rs_hw", halt_b, 0);
    pclk_2 = 1'b1;
    tick();
    pclk_2 = 1'b0;
    tick();
    tick(); tick();
    chk("rs_dma", dma_grant, 1);
    repeat (4) tick();
    reset = 1'b1; dma_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("rs_outs", outs(), {4'b1000, 16'h0000});
    chk("rs_cycles", dma_cycles, 0);
    tick();
    chk("rs_after", outs(), {4'b1000, 16'h0000});

    // overrun: kill at DMA cycle 452
    pclk_2 = 1'b1; dma_req = 1'b1;
    tick();
    pclk_2 = 1'b0;
    tick();
    tick(); tick();
    chk("kl_grant", dma_grant, 1);
    bad = 1'b0;
    for (int i = 0; i < 451; i++) begin
      tick();
      if (dma_kill || !dma_grant) bad = 1'b1;
    end
    chk("kl_early", bad, 0);
    tick();
    chk("kl_rel_outs", outs(), {4'b1001, 16'h0000});
    chk("kl_cycles", dma_cycles, 452);
    tick();
    chk("kl_pulse", dma_kill, 0);
    chk("kl_idle_halt", halt_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
